// File: rtl/line_seg_fifo.sv
// line_seg_fifo: first-word-fall-through queue of line segments with occupancy,
// pending-frame count, almost-full threshold, flush and sticky error flags.
module line_seg_fifo #(
  parameter int COORD_W   = 13,
  parameter int INT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_start_x,
  input  logic [COORD_W-1:0] wr_start_y,
  input  logic [COORD_W-1:0] wr_end_x,
  input  logic [COORD_W-1:0] wr_end_y,
  input  logic [INT_W-1:0]   wr_intensity,
  input  logic               wr_eof,
  output logic               full,
  output logic               almost_full,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [COORD_W-1:0] rd_start_x,
  output logic [COORD_W-1:0] rd_start_y,
  output logic [COORD_W-1:0] rd_end_x,
  output logic [COORD_W-1:0] rd_end_y,
  output logic [INT_W-1:0]   rd_intensity,
  output logic               rd_eof,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      frames_pending,
  output logic               overflow,
  output logic               underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 * COORD_W + INT_W + 1;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_frames;
  logic          r_ovf, r_udf;
  logic          w_push, w_pop;
  logic [EW-1:0] w_head;
  assign full           = r_count == CW'(DEPTH);
  assign almost_full    = r_count >= CW'(AF_THRESH);
  assign rd_valid       = r_count != '0;
  assign count          = r_count;
  assign frames_pending = r_frames;
  assign overflow       = r_ovf;
  assign underflow      = r_udf;
  // a push into a full queue is still taken when the head leaves in the same cycle
  assign w_push = wr_en && (!full || rd_en) && !flush;
  assign w_pop  = rd_en && rd_valid && !flush;
  assign w_head = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign {rd_start_x, rd_start_y, rd_end_x, rd_end_y, rd_intensity, rd_eof} = w_head;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_intensity, wr_eof};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_frames <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_frames <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_frames <= r_frames + CW'(w_push && wr_eof) - CW'(w_pop && rd_eof);
      if (wr_en && full && !rd_en) r_ovf <= 1'b1;
      if (rd_en && !rd_valid) r_udf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_line_seg_fifo.sv
// tb_line_seg_fifo: directed checks of the default queue plus a randomized
// reference-queue comparison on a small DEPTH=4 instance.
module tb_line_seg_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  logic        a_flush = 0, a_wr_en = 0, a_wr_eof = 0, a_rd_en = 0;
  logic [12:0] a_wsx = 0, a_wsy = 0, a_wex = 0, a_wey = 0;
  logic [3:0]  a_wint = 0;
  logic        a_full, a_af, a_rd_valid, a_rd_eof, a_ovf, a_udf;
  logic [12:0] a_rsx, a_rsy, a_rex, a_rey;
  logic [3:0]  a_rint;
  logic [4:0]  a_count, a_fp;

  line_seg_fifo dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr_en),
    .wr_start_x(a_wsx), .wr_start_y(a_wsy), .wr_end_x(a_wex), .wr_end_y(a_wey),
    .wr_intensity(a_wint), .wr_eof(a_wr_eof), .full(a_full), .almost_full(a_af),
    .rd_en(a_rd_en), .rd_valid(a_rd_valid), .rd_start_x(a_rsx), .rd_start_y(a_rsy),
    .rd_end_x(a_rex), .rd_end_y(a_rey), .rd_intensity(a_rint), .rd_eof(a_rd_eof),
    .count(a_count), .frames_pending(a_fp), .overflow(a_ovf), .underflow(a_udf)
  );

  logic        b_wr_en = 0, b_rd_en = 0, b_wr_eof = 0;
  logic [9:0]  b_wsx = 0, b_wsy = 0, b_wex = 0, b_wey = 0;
  logic [3:0]  b_wint = 0;
  logic        b_full, b_af, b_rd_valid, b_rd_eof, b_ovf, b_udf;
  logic [9:0]  b_rsx, b_rsy, b_rex, b_rey;
  logic [3:0]  b_rint;
  logic [2:0]  b_count, b_fp;

  line_seg_fifo #(.COORD_W(10), .INT_W(4), .DEPTH(4), .AF_THRESH(3)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .wr_en(b_wr_en),
    .wr_start_x(b_wsx), .wr_start_y(b_wsy), .wr_end_x(b_wex), .wr_end_y(b_wey),
    .wr_intensity(b_wint), .wr_eof(b_wr_eof), .full(b_full), .almost_full(b_af),
    .rd_en(b_rd_en), .rd_valid(b_rd_valid), .rd_start_x(b_rsx), .rd_start_y(b_rsy),
    .rd_end_x(b_rex), .rd_end_y(b_rey), .rd_intensity(b_rint), .rd_eof(b_rd_eof),
    .count(b_count), .frames_pending(b_fp), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of the default instance; fields are derived from sx
  task automatic cyc(input logic w, input logic r, input logic [12:0] sx, input logic eof);
    a_wr_en = w; a_rd_en = r; a_wr_eof = eof;
    a_wsx = sx; a_wsy = sx ^ 13'h0155; a_wex = sx + 13'd7; a_wey = ~sx; a_wint = sx[3:0];
    tick();
    a_wr_en = 0; a_rd_en = 0; a_wr_eof = 0;
  endtask

  logic [9:0] q [$];
  logic       bp, bq;

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_valid", 32'(a_rd_valid), 0);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_af", 32'(a_af), 0);
    chk("rst_fp", 32'(a_fp), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_udf", 32'(a_udf), 0);
    chk("rst_sx", 32'(a_rsx), 0);

    cyc(1, 0, 13'd1, 0);
    chk("t1_valid", 32'(a_rd_valid), 1);
    chk("t1_head", 32'(a_rsx), 1);
    chk("t1_sy", 32'(a_rsy), 32'h0154);
    chk("t1_ey", 32'(a_rey), 32'h1ffe);
    chk("t1_int", 32'(a_rint), 1);
    cyc(1, 0, 13'd2, 0);
    cyc(1, 0, 13'd3, 0);
    chk("t1_count3", 32'(a_count), 3);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_pop_head", 32'(a_rsx), 32'(i));
      cyc(0, 1, 0, 0);
      chk("t1_pop_count", 32'(a_count), 32'(3 - i));
    end
    chk("t1_empty_valid", 32'(a_rd_valid), 0);
    chk("t1_empty_sx", 32'(a_rsx), 0);
    chk("t1_empty_ex", 32'(a_rex), 0);
    chk("t1_empty_ey", 32'(a_rey), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 13'(100 + i), 0);
      chk("t2_af", 32'(a_af), 32'(i + 1 >= 12));
      chk("t2_full", 32'(a_full), 32'(i == 15));
    end
    cyc(1, 0, 13'd999, 0);
    chk("t2_ovf", 32'(a_ovf), 1);
    chk("t2_ovf_count", 32'(a_count), 16);
    chk("t2_ovf_head", 32'(a_rsx), 100);
    cyc(1, 1, 13'd200, 0);
    chk("t2_pp_count", 32'(a_count), 16);
    chk("t2_pp_full", 32'(a_full), 1);
    chk("t2_pp_head", 32'(a_rsx), 101);
    for (int i = 0; i < 15; i++) begin
      chk("t2_drain", 32'(a_rsx), 32'(101 + i));
      cyc(0, 1, 0, 0);
    end
    chk("t2_tail", 32'(a_rsx), 200);
    cyc(0, 1, 0, 0);
    chk("t2_drained", 32'(a_count), 0);

    chk("t3_udf_before", 32'(a_udf), 0);
    cyc(1, 1, 13'd7, 0);
    chk("t3_count", 32'(a_count), 1);
    chk("t3_udf", 32'(a_udf), 1);
    chk("t3_valid", 32'(a_rd_valid), 1);
    chk("t3_head", 32'(a_rsx), 7);
    cyc(0, 1, 0, 0);

    for (int i = 1; i <= 5; i++) cyc(1, 0, 13'(i), (i == 2 || i == 5));
    chk("t4_fp2", 32'(a_fp), 2);
    chk("t4_eof1", 32'(a_rd_eof), 0);
    cyc(0, 1, 0, 0);
    chk("t4_fp_pop1", 32'(a_fp), 2);
    chk("t4_eof2", 32'(a_rd_eof), 1);
    cyc(0, 1, 0, 0);
    chk("t4_fp_pop2", 32'(a_fp), 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t4_eof5", 32'(a_rd_eof), 1);
    cyc(1, 1, 13'd6, 1);
    chk("t4_fp_both", 32'(a_fp), 1);
    chk("t4_count_both", 32'(a_count), 1);
    chk("t4_head6", 32'(a_rsx), 6);

    for (int i = 0; i < 9; i++) cyc(1, 0, 13'(300 + i), 0);
    chk("t5_count10", 32'(a_count), 10);
    a_flush = 1;
    cyc(1, 1, 13'd77, 1);
    a_flush = 0;
    chk("t5_count", 32'(a_count), 0);
    chk("t5_fp", 32'(a_fp), 0);
    chk("t5_valid", 32'(a_rd_valid), 0);
    chk("t5_sx", 32'(a_rsx), 0);
    chk("t5_ovf", 32'(a_ovf), 1);
    chk("t5_udf", 32'(a_udf), 1);
    cyc(1, 0, 13'd55, 0);
    chk("t5_after_head", 32'(a_rsx), 55);
    chk("t5_after_count", 32'(a_count), 1);

    for (int i = 0; i < 200; i++) begin
      bp = ($urandom_range(0, 99) < 80);
      bq = ($urandom_range(0, 99) < 75);
      b_wr_en = bp; b_rd_en = bq;
      b_wsx = 10'(i * 37 + 5); b_wsy = 0; b_wex = 0; b_wey = 0; b_wint = 0;
      chk("rnd_count", 32'(b_count), 32'(q.size()));
      chk("rnd_valid", 32'(b_rd_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("rnd_head", 32'(b_rsx), 32'(q[0]));
      if (bq && q.size() > 0) void'(q.pop_front());
      else if (bp && bq && q.size() == 0) begin end
      if (bp && (q.size() < 4)) q.push_back(b_wsx);
      tick();
    end
    b_wr_en = 0; b_rd_en = 0;
    chk("rnd_final_count", 32'(b_count), 32'(q.size()));
    chk("rnd_ovf_none", 32'(b_count <= 3'd4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
